// File: rtl/booth2_operand_stage_if.sv
// Handshake bundle for the Booth operand stage: input pair channel
// (in_*) and registered operand/code channel (out_*).
interface booth2_operand_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_a;
  logic [15:0] out_inversed_a;
  logic        out_a_is_min;
  logic [23:0] out_booth_code;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_a,
    input  out_inversed_a, out_a_is_min,
    input  out_booth_code
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_a,
    output out_inversed_a, out_a_is_min,
    output out_booth_code
  );
endinterface

// File: rtl/booth2_operand_stage.sv
// Booth radix-4 operand stage: registers A, -A, A==min and 8 Booth codes of B.
// Ports: sys_clk, sys_rst_n (async low), bus (slave: in_* pair in, out_* out).
module booth2_operand_stage (
  input logic                    sys_clk,
  input logic                    sys_rst_n,
  booth2_operand_stage_if.slave  bus
);

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] inv;
    logic        is_min;
    logic [23:0] code;
  } pair_t;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO
  } state_e;

  state_e      state_q;
  pair_t       out_q;
  pair_t       skid_q;
  pair_t       pair_d;
  logic        valid_q;
  logic        ready_q;
  logic [16:0] bext;
  logic        accept;

  // B with an implicit zero below bit 0, so code k is bext[2k+2:2k].
  always_comb begin
    pair_d        = '0;
    bext          = {bus.in_b, 1'b0};
    pair_d.a      = bus.in_a;
    pair_d.inv    = ~bus.in_a + 16'd1;
    pair_d.is_min = (bus.in_a == 16'h8000);
    for (int k = 0; k < 8; k++) begin
      pair_d.code[3*k +: 3] = bext[2*k +: 3];
    end
  end

  assign accept = bus.in_valid & ready_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            out_q   <= pair_d;
            valid_q <= 1'b1;
            state_q <= ONE;
          end
        end
        ONE: begin
          if (accept && bus.out_ready) begin
            out_q <= pair_d;
          end else if (accept) begin
            skid_q  <= pair_d;
            ready_q <= 1'b0;
            state_q <= TWO;
          end else if (bus.out_ready) begin
            valid_q <= 1'b0;
            state_q <= EMPTY;
          end
        end
        TWO: begin
          if (bus.out_ready) begin
            out_q   <= skid_q;
            skid_q  <= '0;
            ready_q <= 1'b1;
            state_q <= ONE;
          end
        end
        default: begin
          state_q <= EMPTY;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready       = ready_q;
  assign bus.out_valid      = valid_q;
  assign bus.out_a          = out_q.a;
  assign bus.out_inversed_a = out_q.inv;
  assign bus.out_a_is_min   = out_q.is_min;
  assign bus.out_booth_code = out_q.code;

endmodule

// File: tb/tb_booth2_operand_stage.sv
// Bench for booth2_operand_stage: directed vectors plus a queue scoreboard.
// Expected pairs come from an arithmetic model of negation and Booth digits.
module tb_booth2_operand_stage;

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   n_out = 0;

  booth2_operand_stage_if bus ();

  booth2_operand_stage dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] inv;
    logic        m;
    logic [23:0] c;
  } exp_t;

  exp_t q[$];

  function automatic exp_t model(logic [15:0] a, logic [15:0] b);
    exp_t e;
    int   bx;
    e.a   = a;
    e.inv = 16'(32'd65536 - {16'd0, a});
    e.m   = (a == 16'h8000);
    e.c   = '0;
    bx    = int'(b) * 2;
    for (int k = 0; k < 8; k++) begin
      e.c = e.c | (24'((bx / (1 << (2 * k))) % 8) << (3 * k));
    end
    return e;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Scoreboard and stall-stability monitor, sampled mid-cycle.
  logic        stall_prev = 1'b0;
  logic [56:0] held;

  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      q.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stable", {bus.out_a, bus.out_inversed_a,
            bus.out_a_is_min, bus.out_booth_code}, {7'd0, held});
      end
      if (bus.out_valid && bus.out_ready) begin
        n_out++;
        if (q.size() == 0) begin
          chk("extra_out", 1'b1, 1'b0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("out_a", bus.out_a, e.a);
          chk("out_inv", bus.out_inversed_a, e.inv);
          chk("out_min", bus.out_a_is_min, e.m);
          chk("out_code", bus.out_booth_code, e.c);
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(model(bus.in_a, bus.in_b));
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      held = {bus.out_a, bus.out_inversed_a,
              bus.out_a_is_min, bus.out_booth_code};
    end
  end

  // Offer a pair and return #1 after the edge that accepted it.
  task automatic push(logic [15:0] a, logic [15:0] b);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_a = a;
    bus.in_b = b;
    forever begin
      @(negedge sys_clk);
      if (bus.in_ready) begin
        @(posedge sys_clk);
        #1;
        break;
      end
      n++;
      if (n > 1000) begin
        chk("push_timeout", 1'b1, 1'b0);
        @(posedge sys_clk);
        #1;
        break;
      end
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    while (bus.out_valid && n < 100) begin
      tick(1);
      n++;
    end
    tick(1);
    chk("drained_valid", bus.out_valid, 1'b0);
    chk("drained_q", q.size(), 0);
  endtask

  task automatic chk_zero(string nm);
    chk({nm, "_valid"}, bus.out_valid, 1'b0);
    chk({nm, "_ready"}, bus.in_ready, 1'b1);
    chk({nm, "_a"}, bus.out_a, 16'h0);
    chk({nm, "_inv"}, bus.out_inversed_a, 16'h0);
    chk({nm, "_min"}, bus.out_a_is_min, 1'b0);
    chk({nm, "_code"}, bus.out_booth_code, 24'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   n0;
    logic acc;

    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.out_ready = 1'b0;

    // Pin the model against hand-derived values.
    e = model(16'h0003, 16'h0006);
    chk("model_inv3", e.inv, 16'hFFFD);
    chk("model_code6", e.c, 24'h00001C);
    e = model(16'h8000, 16'hFFFF);
    chk("model_min", {e.inv, e.m}, {16'h8000, 1'b1});
    chk("model_codeFFFF", e.c, 24'hFFFFFE);

    tick(2);
    chk_zero("reset");
    sys_rst_n = 1'b1;
    tick(1);

    // Small positive operands.
    bus.out_ready = 1'b1;
    push(16'h0003, 16'h0006);
    bus.in_valid = 1'b0;
    chk("t1_valid", bus.out_valid, 1'b1);
    chk("t1_inv", bus.out_inversed_a, 16'hFFFD);
    chk("t1_code", bus.out_booth_code, 24'h00001C);
    chk("t1_min", bus.out_a_is_min, 1'b0);
    tick(1);
    chk("t1_empty", bus.out_valid, 1'b0);

    // Most negative A, all-ones B.
    push(16'h8000, 16'hFFFF);
    bus.in_valid = 1'b0;
    chk("t2_inv", bus.out_inversed_a, 16'h8000);
    chk("t2_min", bus.out_a_is_min, 1'b1);
    chk("t2_code", bus.out_booth_code, 24'hFFFFFE);
    tick(1);

    // Full-throughput stream.
    n0 = n_out;
    for (int i = 0; i < 100; i++) begin
      push(16'($urandom), 16'($urandom));
      chk("t3_ready", bus.in_ready, 1'b1);
    end
    bus.in_valid = 1'b0;
    tick(1);
    chk("t3_count", n_out - n0, 100);
    drain();

    // Fill both slots under back-pressure.
    bus.out_ready = 1'b0;
    push(16'h1111, 16'h2222);
    push(16'h3333, 16'h4444);
    bus.in_a = 16'h5555;
    bus.in_b = 16'h6666;
    chk("t4_full", bus.in_ready, 1'b0);
    chk("t4_head", bus.out_a, 16'h1111);
    tick(3);
    chk("t4_hold_ready", bus.in_ready, 1'b0);
    chk("t4_hold_head", bus.out_a, 16'h1111);
    bus.out_ready = 1'b1;
    push(16'h5555, 16'h6666);
    bus.in_valid = 1'b0;
    drain();
    chk("t4_ready_back", bus.in_ready, 1'b1);

    // Random handshakes.
    for (int i = 0; i < 10000; i++) begin
      @(negedge sys_clk);
      acc = bus.in_valid && bus.in_ready;
      @(posedge sys_clk);
      #1;
      if (acc || !bus.in_valid) begin
        bus.in_valid = 1'($urandom);
        bus.in_a = 16'($urandom);
        bus.in_b = 16'($urandom);
      end
      bus.out_ready = 1'($urandom);
    end
    drain();

    // Asynchronous reset while full.
    bus.out_ready = 1'b0;
    push(16'h0101, 16'h0202);
    push(16'h0303, 16'h0404);
    bus.in_valid = 1'b0;
    chk("t6_full", bus.in_ready, 1'b0);
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk_zero("t6_async");
    tick(1);
    sys_rst_n = 1'b1;
    tick(1);
    bus.out_ready = 1'b1;
    push(16'h0007, 16'h0001);
    bus.in_valid = 1'b0;
    chk("t6_lat_valid", bus.out_valid, 1'b1);
    chk("t6_lat_a", bus.out_a, 16'h0007);
    chk("t6_lat_code", bus.out_booth_code, 24'h000002);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
